uart_tx_arbiter: RTL and testbench

Packet-level arbiter and sequencer that shares the single UART transmitter between two byte-stream requesters. Requester 0 is the SD-card data path; requester 1 is the host-command response path (for example, the CID dump). The block accepts one byte at a time over a valid/ready handshake and loads it into the transmit register. It starts the transmitter, then waits for the transmitter's sending flag to rise and fall before it accepts the next byte. It sits between the requesters and the UART tx/ctrl registers, replacing direct ad-hoc writes to those registers.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two packet requesters.
//   Ports: clk, reset (async, active-high), sw_reset (sync soft clear);
//   req0_*/req1_* valid/data/last/ready byte handshakes;
//   tx_sending from the transmitter; tx_data/tx_reg_en/tx_reset/uart_tx_en/ctrl_reg_en
//   drive the UART tx and ctrl registers; grant, busy, byte_count, timeout_err status.
//   Optional watchdog on WAIT_BUSY enabled by macro UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  input  logic        tx_sending,
  output logic [7:0]  tx_data,
  output logic        tx_reg_en,
  output logic        tx_reset,
  output logic        uart_tx_en,
  output logic        ctrl_reg_en,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] byte_count,
  output logic        timeout_err
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_last_q, hold_last_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_served_q, last_served_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic        kill, sel, idle, tmo_fire;
  // Outputs are forced low while either reset is asserted.
  assign kill = reset | sw_reset;
  // Selected requester index: the owner while locked, else round-robin on a tie.
  assign sel = |grant_q ? grant_q[1] : (req0_valid & req1_valid) ? ~last_served_q : req1_valid;
  assign idle = (state_q == IDLE) & ~kill;
  assign req0_ready = idle & req0_valid & ~sel;
  assign req1_ready = idle & req1_valid & sel;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic          timeout_err_q, timeout_err_d;
  assign tmo_inc  = tmo_cnt_q + CW'(1);
  // A byte that started sending is never timed out in the same cycle.
  assign tmo_fire = (state_q == WAIT_BUSY) & ~tx_sending & (tmo_inc == CW'(TIMEOUT_CYCLES));
  always_comb begin
    tmo_cnt_d = state_q == LOAD ? '0 : state_q == WAIT_BUSY ? tmo_inc : tmo_cnt_q;
    timeout_err_d = timeout_err_q | tmo_fire;
    if (sw_reset) begin
      tmo_cnt_d = '0;
      timeout_err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q & ~kill;
`else
  assign tmo_fire = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    grant_d = grant_q;
    last_served_d = last_served_q;
    byte_count_d = byte_count_q;
    case (state_q)
      IDLE: if (req0_ready | req1_ready) begin
        hold_data_d = sel ? req1_data : req0_data;
        hold_last_d = sel ? req1_last : req0_last;
        grant_d = sel ? 2'b10 : 2'b01;
        state_d = LOAD;
      end
      LOAD: state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_sending) begin
        state_d = WAIT_DONE;
      end else if (tmo_fire) begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: if (!tx_sending) begin
        state_d = IDLE;
        byte_count_d = byte_count_q + 16'd1;
        if (hold_last_q) begin
          grant_d = 2'b00;
          last_served_d = grant_q[1];
        end
      end
    endcase
    if (sw_reset) begin
      state_d = IDLE;
      hold_data_d = '0;
      hold_last_d = 1'b0;
      grant_d = '0;
      last_served_d = 1'b1;
      byte_count_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      grant_q <= '0;
      last_served_q <= 1'b1;
      byte_count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      grant_q <= grant_d;
      last_served_q <= last_served_d;
      byte_count_q <= byte_count_d;
    end
  end
  assign tx_data     = kill ? 8'h00 : hold_data_q;
  assign tx_reg_en   = ~kill & (state_q == LOAD);
  assign tx_reset    = ~kill & (state_q == LOAD);
  assign uart_tx_en  = ~kill & ((state_q == LOAD) | ((state_q == WAIT_BUSY) & ~tmo_fire) |
                                ((state_q == WAIT_DONE) & tx_sending));
  assign ctrl_reg_en = ~kill & (state_q != IDLE);
  assign grant       = kill ? 2'b00 : grant_q;
  assign busy        = ~kill & (state_q != IDLE);
  assign byte_count  = kill ? 16'h0000 : byte_count_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sw_reset = 1'b0;
  logic        req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic [7:0]  req0_data = 8'h00;
  logic        req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [7:0]  req1_data = 8'h00;
  logic        tx_sending = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_reg_en, tx_reset, uart_tx_en, ctrl_reg_en, busy, timeout_err;
  logic [1:0]  grant;
  logic [15:0] byte_count;
  int tests = 0;
  int failed = 0;
  uart_tx_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .sw_reset(sw_reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_sending(tx_sending), .tx_data(tx_data), .tx_reg_en(tx_reg_en), .tx_reset(tx_reset),
    .uart_tx_en(uart_tx_en), .ctrl_reg_en(ctrl_reg_en), .grant(grant), .busy(busy),
    .byte_count(byte_count), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Transmitter model: called in WAIT_BUSY, keeps sending for n cycles, returns in IDLE.
  task automatic run_tx(input int n);
    tx_sending = 1'b1;
    tick();
    repeat (n - 1) tick();
    tx_sending = 1'b0;
    tick();
  endtask
  initial begin
    req0_valid = 1'b1;
    tick();
    #1;
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_count", 32'(byte_count), 0);
    chk("rst_ctrl", 32'(ctrl_reg_en), 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();
    req0_valid = 1'b1; req0_data = 8'hA5; req0_last = 1'b1;
    #1;
    chk("t1_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_tx_reg_en", 32'(tx_reg_en), 1);
    chk("t1_tx_reset", 32'(tx_reset), 1);
    chk("t1_grant", 32'(grant), 1);
    chk("t1_ready_load", 32'(req0_ready), 0);
    tick();
    chk("t1_wb_en", 32'(uart_tx_en), 1);
    chk("t1_wb_regen", 32'(tx_reg_en), 0);
    tx_sending = 1'b1;
    tick();
    repeat (9) tick();
    chk("t1_wd_busy", 32'(busy), 1);
    chk("t1_wd_en", 32'(uart_tx_en), 1);
    tx_sending = 1'b0;
    #1;
    chk("t1_done_en", 32'(uart_tx_en), 0);
    chk("t1_done_ctrl", 32'(ctrl_reg_en), 1);
    tick();
    chk("t1_count", 32'(byte_count), 1);
    chk("t1_grant_rel", 32'(grant), 0);
    chk("t1_idle", 32'(busy), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hB1; req1_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_ready0", 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
      chk("t2_ready1", 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
      tick();
      chk("t2_tx_data", 32'(tx_data), (k % 2 == 0) ? 32'hA0 : 32'hB1);
      tick();
      run_tx(2);
    end
    chk("t2_count", 32'(byte_count), 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h11; req1_last = 1'b0;
    #1;
    chk("t3_r1_first", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b1;
    #1;
    chk("t3_data11", 32'(tx_data), 32'h11);
    chk("t3_grant1", 32'(grant), 2);
    chk("t3_r0_load", 32'(req0_ready), 0);
    tick();
    run_tx(2);
    req1_valid = 1'b1; req1_data = 8'h22;
    #1;
    chk("t3_r0_lock_a", 32'(req0_ready), 0);
    chk("t3_r1_22", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("t3_data22", 32'(tx_data), 32'h22);
    tick();
    run_tx(2);
    req1_valid = 1'b1; req1_data = 8'h33; req1_last = 1'b1;
    #1;
    chk("t3_r0_lock_b", 32'(req0_ready), 0);
    chk("t3_r1_33", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    tick();
    run_tx(2);
    #1;
    chk("t3_r0_after", 32'(req0_ready), 1);
    chk("t3_grant_rel", 32'(grant), 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t3_data5a", 32'(tx_data), 32'h5A);
    chk("t3_grant0", 32'(grant), 1);
    tick();
    run_tx(2);
    chk("t3_count", 32'(byte_count), 8);
    req0_valid = 1'b1; req0_data = 8'h77; req0_last = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    tx_sending = 1'b1;
    tick();
    chk("t4_in_wd", 32'(busy), 1);
    sw_reset = 1'b1;
    #1;
    chk("t4_sw_busy", 32'(busy), 0);
    chk("t4_sw_grant", 32'(grant), 0);
    chk("t4_sw_count", 32'(byte_count), 0);
    chk("t4_sw_en", 32'(uart_tx_en), 0);
    chk("t4_sw_ctrl", 32'(ctrl_reg_en), 0);
    chk("t4_sw_data", 32'(tx_data), 0);
    tick();
    sw_reset = 1'b0;
    tx_sending = 1'b0;
    #1;
    chk("t4_post_busy", 32'(busy), 0);
    chk("t4_post_grant", 32'(grant), 0);
    chk("t4_post_count", 32'(byte_count), 0);
    chk("t4_post_ctrl", 32'(ctrl_reg_en), 0);
    req0_valid = 1'b1; req0_data = 8'h3C; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h4D; req1_last = 1'b1;
    #1;
    chk("t4_ready0", 32'(req0_ready), 1);
    chk("t4_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t4_data3c", 32'(tx_data), 32'h3C);
    tick();
    run_tx(2);
    chk("t4_count", 32'(byte_count), 1);
    req0_valid = 1'b1; req0_data = 8'h99; req0_last = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t5_wb_en", 32'(uart_tx_en), 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (7) tick();
    chk("t5_pre_busy", 32'(busy), 1);
    chk("t5_pre_err", 32'(timeout_err), 0);
    chk("t5_fire_en", 32'(uart_tx_en), 0);
    chk("t5_fire_ctrl", 32'(ctrl_reg_en), 1);
    tick();
    chk("t5_err", 32'(timeout_err), 1);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_grant", 32'(grant), 0);
    chk("t5_count", 32'(byte_count), 1);
    req1_valid = 1'b1; req1_data = 8'h42; req1_last = 1'b1;
    #1;
    chk("t5_unlocked", 32'(req1_ready), 1);
    req1_valid = 1'b0;
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    #1;
    chk("t5_err_clr", 32'(timeout_err), 0);
`else
    repeat (20) tick();
    chk("t6_busy", 32'(busy), 1);
    chk("t6_err", 32'(timeout_err), 0);
    chk("t6_en", 32'(uart_tx_en), 1);
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    #1;
    chk("t6_cleared", 32'(busy), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
